// File: rtl/mult_share_sched.sv
// Round-robin scheduler that time-shares one 4x4 multiplier core between NREQ requesters.
// Optional MULT_SHARE_SELFCHK_EN adds chk_err, a sticky flag for a core/reference product mismatch.

module mult4x4_core (
   input  logic [3:0] x,
   input  logic [3:0] y,
   output logic [7:0] o
);
   logic [7:0] w_pp [4];

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_pp[i] = {4'b0000, x & {4{y[i]}}} << i;
      end
      o = w_pp[0] + w_pp[1] + w_pp[2] + w_pp[3];
   end
endmodule

// state | meaning
// IDLE  | arbitrate; accept the round-robin winner at the edge
// CALC  | op regs drive the core; capture its product
// RESP  | hold rsp_valid/rsp_prod/rsp_id until rsp_ready
module mult_share_sched #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [4*NREQ-1:0] req_x,
   input  logic [4*NREQ-1:0] req_y,
   output logic [NREQ-1:0]   req_ready,
   output logic              rsp_valid,
   output logic [IDW-1:0]    rsp_id,
   output logic [7:0]        rsp_prod,
   input  logic              rsp_ready,
`ifdef MULT_SHARE_SELFCHK_EN
   output logic              chk_err,
`endif
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

   localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
   localparam logic [IDW-1:0] LAST   = IDW'(NREQ - 1);

   state_t           r_state;
   logic [IDW-1:0]   r_rr_ptr;
   logic [3:0]       r_op_x;
   logic [3:0]       r_op_y;
   logic [IDW-1:0]   r_id;
   logic [7:0]       r_rsp_prod;
   logic [IDW-1:0]   r_rsp_id;
   logic             r_rsp_valid;
   logic             r_busy;

   logic [NREQ-1:0]  w_grant_oh;
   logic [IDW-1:0]   w_grant_idx;
   logic             w_any;
   logic [IDW:0]     w_scan;
   logic [IDW-1:0]   w_next_ptr;
   logic [7:0]       w_core_o;

   // Scan rr_ptr, rr_ptr+1, ... modulo NREQ; first valid requester wins.
   always_comb begin
      w_grant_oh  = '0;
      w_grant_idx = '0;
      w_any       = 1'b0;
      w_scan      = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_scan = {1'b0, r_rr_ptr} + (IDW+1)'(k);
         if (w_scan >= NREQ_W) begin
            w_scan = w_scan - NREQ_W;
         end
         if (!w_any && req_valid[w_scan[IDW-1:0]]) begin
            w_any                       = 1'b1;
            w_grant_idx                 = w_scan[IDW-1:0];
            w_grant_oh[w_scan[IDW-1:0]] = 1'b1;
         end
      end
   end

   assign w_next_ptr = (w_grant_idx == LAST) ? '0 : w_grant_idx + 1'b1;
   assign req_ready  = (r_state == IDLE) ? w_grant_oh : '0;

   mult4x4_core u_core (
      .x (r_op_x),
      .y (r_op_y),
      .o (w_core_o)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_rr_ptr    <= '0;
         r_op_x      <= '0;
         r_op_y      <= '0;
         r_id        <= '0;
         r_rsp_prod  <= '0;
         r_rsp_id    <= '0;
         r_rsp_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_op_x   <= req_x[4*w_grant_idx +: 4];
                  r_op_y   <= req_y[4*w_grant_idx +: 4];
                  r_id     <= w_grant_idx;
                  r_rr_ptr <= w_next_ptr;
                  r_busy   <= 1'b1;
                  r_state  <= CALC;
               end
            end
            CALC: begin
               r_rsp_prod  <= w_core_o;
               r_rsp_id    <= r_id;
               r_rsp_valid <= 1'b1;
               r_state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_rsp_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_prod  = r_rsp_prod;
   assign busy      = r_busy;

`ifdef MULT_SHARE_SELFCHK_EN
   logic       r_chk_err;
   logic [7:0] w_ref;

   assign w_ref = {4'b0000, r_op_x} * {4'b0000, r_op_y};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chk_err <= 1'b0;
      end else if (r_state == CALC && w_core_o != w_ref) begin
         r_chk_err <= 1'b1;
      end
   end

   assign chk_err = r_chk_err;
`endif
endmodule
